// File: rtl/inst_mem_responder_if.sv
// Fetch request/response channel between the processor fetch stage and
// inst_mem_responder: valid/ready request carrying the PC, valid/ready response.
interface inst_mem_responder_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [31:0] REQ_ADDR;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic [31:0] INSTRUCTION;
  logic        RESP_ERR;

  modport master (
    output REQ_VALID, REQ_ADDR, RESP_READY,
    input  REQ_READY, RESP_VALID, INSTRUCTION, RESP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, RESP_READY,
    output REQ_READY, RESP_VALID, INSTRUCTION, RESP_ERR
  );
endinterface

// File: rtl/inst_mem_responder.sv
// Byte-wide instruction memory: reads four bytes per fetch, one per cycle, and returns a
// little-endian word. Define NEXT_WORD_PREFETCH_EN to add a next-word prefetch buffer.
module inst_mem_responder #(
  parameter int DEPTH_BYTES = 32,
  parameter int ADDR_W      = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  inst_mem_responder_if.slave bus,
  input  logic                LOAD_EN,
  input  logic [ADDR_W-1:0]   LOAD_ADDR,
  input  logic [7:0]          LOAD_DATA
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
`ifdef NEXT_WORD_PREFETCH_EN
    S_PREFETCH = 2'd3,
`endif
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH_BYTES];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              err_q, err_d;
  // skip_q: one pass through READ without reading (error or buffer-hit responses)
  logic              skip_q, skip_d;
  logic              take_new;
  logic              req_aligned, req_in_range;
  logic [7:0]        rd_byte;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{k, 3'b000} +: 8] = b;
    return r;
  endfunction

  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign req_aligned  = (bus.REQ_ADDR[1:0] == 2'b00);
  assign req_in_range = (({1'b0, bus.REQ_ADDR} + 33'd3) < 33'(DEPTH_BYTES));
  assign rd_byte      = mem[addr_q + ADDR_W'(cnt_q)];

`ifdef NEXT_WORD_PREFETCH_EN
  logic [31:0]       pbuf_q, pbuf_d;
  logic              pvld_q, pvld_d;
  logic [ADDR_W-1:0] ptag_q, ptag_d;
  logic [1:0]        pcnt_q, pcnt_d;
  logic              pf_match, hit, nxt_in_range;
  logic [7:0]        pf_byte;

  assign pf_match     = req_aligned && req_in_range && (bus.REQ_ADDR[ADDR_W-1:0] == ptag_q);
  assign hit          = pf_match && pvld_q && !LOAD_EN;
  assign pf_byte      = mem[ptag_q + ADDR_W'(pcnt_q)];
  assign nxt_in_range = ((32'(addr_q) + 32'd7) < 32'(DEPTH_BYTES));
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    instr_d  = instr_q;
    err_d    = err_q;
    skip_d   = skip_q;
    take_new = 1'b0;
`ifdef NEXT_WORD_PREFETCH_EN
    pbuf_d = pbuf_q;
    pvld_d = pvld_q;
    ptag_d = ptag_q;
    pcnt_d = pcnt_q;
`endif
    case (state_q)
      S_IDLE: take_new = bus.REQ_VALID;
      S_READ: begin
        if (skip_q) begin
          skip_d  = 1'b0;
          state_d = S_RESP;
        end else begin
          instr_d = put_byte(instr_q, cnt_q, rd_byte);
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.RESP_READY) begin
          state_d = S_IDLE;
`ifdef NEXT_WORD_PREFETCH_EN
          if (!err_q && nxt_in_range) begin
            state_d = S_PREFETCH;
            ptag_d  = addr_q + ADDR_W'(4);
            pcnt_d  = 2'd0;
            pvld_d  = 1'b0;
            pbuf_d  = '0;
          end
`endif
        end
      end
`ifdef NEXT_WORD_PREFETCH_EN
      S_PREFETCH: begin
        if (LOAD_EN || (bus.REQ_VALID && !pf_match)) begin
          state_d  = S_IDLE;
          take_new = bus.REQ_VALID;
        end else if (bus.REQ_VALID) begin
          // Matching fetch picks up where the prefetch left off
          state_d = S_READ;
          addr_d  = ptag_q;
          cnt_d   = pcnt_q;
          instr_d = pbuf_q;
          err_d   = 1'b0;
          skip_d  = 1'b0;
        end else begin
          pbuf_d = put_byte(pbuf_q, pcnt_q, pf_byte);
          pcnt_d = pcnt_q + 2'd1;
          if (pcnt_q == 2'd3) begin
            pvld_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (take_new) begin
      addr_d  = bus.REQ_ADDR[ADDR_W-1:0];
      cnt_d   = 2'd0;
      instr_d = '0;
      state_d = S_READ;
      if (!req_aligned || !req_in_range) begin
        err_d  = 1'b1;
        skip_d = 1'b1;
      end else begin
        err_d  = 1'b0;
        skip_d = 1'b0;
`ifdef NEXT_WORD_PREFETCH_EN
        if (hit) begin
          instr_d = pbuf_q;
          skip_d  = 1'b1;
        end
`endif
      end
    end
`ifdef NEXT_WORD_PREFETCH_EN
    if (LOAD_EN) pvld_d = 1'b0;
`endif
  end

  always_comb begin
    bus.REQ_READY = (state_q == S_IDLE);
`ifdef NEXT_WORD_PREFETCH_EN
    if (state_q == S_PREFETCH) bus.REQ_READY = 1'b1;
`endif
    bus.RESP_VALID  = (state_q == S_RESP);
    bus.INSTRUCTION = instr_q;
    bus.RESP_ERR    = err_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
`ifdef NEXT_WORD_PREFETCH_EN
      pvld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
`ifdef NEXT_WORD_PREFETCH_EN
      pvld_q  <= pvld_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
`ifdef NEXT_WORD_PREFETCH_EN
    pbuf_q <= pbuf_d;
    ptag_q <= ptag_d;
    pcnt_q <= pcnt_d;
`endif
  end

  // Storage is deliberately outside reset so the program image survives RESET
  always_ff @(posedge CLK) begin
    if (LOAD_EN && (32'(LOAD_ADDR) < 32'(DEPTH_BYTES))) mem[LOAD_ADDR] <= LOAD_DATA;
  end

endmodule
